// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// State enum, opcode constants, datapath mux encodings and the raw control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_DATA   = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // fetch marks the cycle whose irwrite/pcen still wait on mem_ready
  typedef struct packed {
    logic       mem_req;
    logic       fetch;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALUOP_AND;
      OP_ORI:  return ALUOP_OR;
      OP_SLTI: return ALUOP_SLT;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decoder for the multicycle controller.
// Handshake qualification and pcen are left to the top level.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op,
  output ctrl_t       cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.mem_req = 1'b1;
        cw.fetch   = 1'b1;
        cw.alusrcb = ALUSRCB_FOUR;
        cw.aluop   = ALUOP_ADD;
        cw.pcsrc   = PCSRC_ALURES;
      end
      DECODE: begin
        cw.alusrcb = ALUSRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      MEMWB: begin
        cw.regdst   = REGDST_RT;
        cw.memtoreg = MEMTOREG_DATA;
        cw.regwrite = 1'b1;
      end
      MEMWR: begin
        cw.mem_req  = 1'b1;
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      EXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_B;
        cw.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        cw.regdst   = REGDST_RD;
        cw.memtoreg = MEMTOREG_ALUOUT;
        cw.regwrite = 1'b1;
      end
      BRANCH: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_B;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
      end
      IEXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_IMM;
        cw.aluop   = imm_aluop(op);
        cw.zeroext = (op == OP_ANDI) || (op == OP_ORI);
      end
      IWB: begin
        cw.regdst   = REGDST_RT;
        cw.memtoreg = MEMTOREG_ALUOUT;
        cw.regwrite = 1'b1;
      end
      JUMP: begin
        cw.pcsrc = PCSRC_JUMP;
      end
      // jal links PC+4 into $ra while jumping
      JAL: begin
        cw.regwrite = 1'b1;
        cw.regdst   = REGDST_RA;
        cw.memtoreg = MEMTOREG_PC;
        cw.pcsrc    = PCSRC_JUMP;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Registered multicycle MIPS main controller with memory handshake and retire counter.
// Optional jal support is enabled by defining JAL_EN.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int ALUOP_W = 3
)
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               pcen,
  output logic [1:0]         pcsrc,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               zeroext,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired
);

  state_t           state_q;
  state_t           state_d;
  ctrl_t            cw;
  logic             pcen_c;
  logic             retire;
  logic             illegal_c;
  logic [CNT_W-1:0] retired_q;

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .op    (op),
    .cw    (cw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // retire is raised on the last cycle of every completed instruction
  always_comb begin
    state_d   = FETCH;
    retire    = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_RTYPE:                          state_d = EXEC;
          OP_BEQ, OP_BNE:                    state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IEXEC;
          OP_J:                              state_d = JUMP;
`ifdef JAL_EN
          OP_JAL:                            state_d = JAL;
`endif
          default: begin
            state_d   = FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  retire  = 1'b1;
      MEMWR: begin
        state_d = mem_ready ? FETCH : MEMWR;
        retire  = mem_ready;
      end
      EXEC:   state_d = ALUWB;
      ALUWB:  retire  = 1'b1;
      BRANCH: retire  = 1'b1;
      IEXEC:  state_d = IWB;
      IWB:    retire  = 1'b1;
      JUMP:   retire  = 1'b1;
      JAL:    retire  = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // fetch only commits PC and IR together on the cycle memory delivers
  always_comb begin
    pcen_c = 1'b0;
    case (state_q)
      FETCH:     pcen_c = mem_ready;
      BRANCH:    pcen_c = (op == OP_BNE) ? ~zero : zero;
      JUMP, JAL: pcen_c = 1'b1;
      default:   pcen_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  // everything is held quiet while reset is asserted, even though state is FETCH
  assign mem_req    = reset_n & cw.mem_req;
  assign pcen       = reset_n & pcen_c;
  assign irwrite    = reset_n & cw.fetch & mem_ready;
  assign iord       = reset_n & cw.iord;
  assign memwrite   = reset_n & cw.memwrite;
  assign regwrite   = reset_n & cw.regwrite;
  assign alusrca    = reset_n & cw.alusrca;
  assign zeroext    = reset_n & cw.zeroext;
  assign illegal_op = reset_n & illegal_c;
  assign pcsrc      = reset_n ? cw.pcsrc    : 2'b00;
  assign regdst     = reset_n ? cw.regdst   : 2'b00;
  assign memtoreg   = reset_n ? cw.memtoreg : 2'b00;
  assign alusrcb    = reset_n ? cw.alusrcb  : 2'b00;
  assign aluop      = reset_n ? ALUOP_W'(cw.aluop) : '0;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: per-instruction cycle model plus literal checks.
// Honours JAL_EN the same way as the design.
module tb_mc_ctrl_unit;

  localparam int CNT_W   = 4;
  localparam int ALUOP_W = 3;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010,
                         JMP = 6'b000010, JALOP = 6'b000011;

  logic               clk;
  logic               reset_n;
  logic [5:0]         opIn;
  logic               zeroIn;
  logic               memReady;
  logic               mem_req, pcen, iord, memwrite, irwrite, regwrite;
  logic               alusrca, zeroext, illegal_op;
  logic [1:0]         pcsrc, regdst, memtoreg, alusrcb;
  logic [ALUOP_W-1:0] aluop;
  logic [CNT_W-1:0]   retired;

  mc_ctrl_unit #(.CNT_W(CNT_W), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .reset_n(reset_n), .op(opIn), .zero(zeroIn), .mem_ready(memReady),
    .mem_req(mem_req), .pcen(pcen), .pcsrc(pcsrc), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop),
    .illegal_op(illegal_op), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [2:0] aluop;
    logic       illegal_op;
  } word_t;

  int compared = 0;
  int mismatched = 0;

  word_t            expQ[$];
  logic [CNT_W-1:0] retQ[$];
  string            tagQ[$];
  logic [CNT_W-1:0] retModel;
  logic [19:0]      actualBits;

  assign actualBits = {mem_req, pcen, pcsrc, iord, memwrite, irwrite, regdst, memtoreg,
                       regwrite, alusrca, alusrcb, zeroext, aluop, illegal_op};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    word_t            w;
    logic [CNT_W-1:0] r;
    string            t;
    if (expQ.size() > 0) begin
      w = expQ.pop_front();
      r = retQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, " ctl"}, 32'(actualBits), 32'(w));
      checkOutput({t, " retired"}, 32'(retired), 32'(r));
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic ready,
                               input word_t w, input logic ret, input string tag);
    opIn     = op;
    zeroIn   = z;
    memReady = ready;
    expQ.push_back(w);
    retQ.push_back(retModel);
    tagQ.push_back(tag);
    if (ret) retModel = retModel + 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic isLegal(input logic [5:0] op);
    case (op)
      RTYPE, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI, JMP: return 1'b1;
`ifdef JAL_EN
      JALOP: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic word_t fetchWord(input logic ready);
    word_t w = '0;
    w.mem_req = 1'b1;
    w.alusrcb = 2'b01;
    w.pcen    = ready;
    w.irwrite = ready;
    return w;
  endfunction

  // expected cycle sequence of one whole instruction, driven and queued together
  task automatic runInstr(input logic [5:0] op, input logic z, input int fw, input int mw);
    word_t w;
    for (int i = 0; i < fw; i++) applyStimulus(op, z, 1'b0, fetchWord(1'b0), 1'b0, "fetch-wait");
    applyStimulus(op, z, 1'b1, fetchWord(1'b1), 1'b0, "fetch");
    w = '0;
    w.alusrcb = 2'b11;
    w.illegal_op = !isLegal(op);
    applyStimulus(op, z, 1'b0, w, 1'b0, "decode");
    if (!isLegal(op)) return;
    case (op)
      LW, SW: begin
        w = '0; w.alusrca = 1'b1; w.alusrcb = 2'b10;
        applyStimulus(op, z, 1'b0, w, 1'b0, "memadr");
        w = '0; w.mem_req = 1'b1; w.iord = 1'b1; w.memwrite = (op == SW);
        for (int i = 0; i < mw; i++) applyStimulus(op, z, 1'b0, w, 1'b0, "mem-wait");
        applyStimulus(op, z, 1'b1, w, op == SW, "mem-accept");
        if (op == LW) begin
          w = '0; w.memtoreg = 2'b01; w.regwrite = 1'b1;
          applyStimulus(op, z, 1'b0, w, 1'b1, "memwb");
        end
      end
      RTYPE: begin
        w = '0; w.alusrca = 1'b1; w.aluop = 3'b010;
        applyStimulus(op, z, 1'b0, w, 1'b0, "exec");
        w = '0; w.regdst = 2'b01; w.regwrite = 1'b1;
        applyStimulus(op, z, 1'b0, w, 1'b1, "aluwb");
      end
      BEQ, BNE: begin
        w = '0; w.alusrca = 1'b1; w.aluop = 3'b001; w.pcsrc = 2'b01;
        w.pcen = (op == BEQ) ? z : !z;
        applyStimulus(op, z, 1'b0, w, 1'b1, "branch");
      end
      JMP: begin
        w = '0; w.pcen = 1'b1; w.pcsrc = 2'b10;
        applyStimulus(op, z, 1'b0, w, 1'b1, "jump");
      end
      JALOP: begin
        w = '0; w.pcen = 1'b1; w.pcsrc = 2'b10; w.regwrite = 1'b1;
        w.regdst = 2'b10; w.memtoreg = 2'b10;
        applyStimulus(op, z, 1'b0, w, 1'b1, "jal");
      end
      default: begin
        w = '0; w.alusrca = 1'b1; w.alusrcb = 2'b10;
        w.aluop = (op == ANDI) ? 3'b011 : (op == ORI) ? 3'b100 : (op == SLTI) ? 3'b101 : 3'b000;
        w.zeroext = (op == ANDI) || (op == ORI);
        applyStimulus(op, z, 1'b0, w, 1'b0, "iexec");
        w = '0; w.regwrite = 1'b1;
        applyStimulus(op, z, 1'b0, w, 1'b1, "iwb");
      end
    endcase
  endtask

  initial begin
    word_t w;
    reset_n  = 1'b0;
    opIn     = LW;
    zeroIn   = 1'b0;
    memReady = 1'b1;
    retModel = '0;
    #2;
    checkOutput("reset outputs", 32'(actualBits), 32'h0);
    checkOutput("reset retired", 32'(retired), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    runInstr(LW, 1'b0, 2, 3);
    checkOutput("retired after lw", 32'(retired), 32'd1);
    runInstr(SW, 1'b0, 0, 2);
    checkOutput("retired after sw", 32'(retired), 32'd2);
    runInstr(BEQ, 1'b1, 0, 0);
    runInstr(BNE, 1'b1, 0, 0);
    checkOutput("retired after branches", 32'(retired), 32'd4);
    runInstr(ORI, 1'b0, 1, 0);
    runInstr(6'b111111, 1'b0, 0, 0);
    checkOutput("retired after illegal", 32'(retired), 32'd5);
    runInstr(RTYPE, 1'b0, 0, 0);
    runInstr(BNE, 1'b0, 0, 0);
    runInstr(BEQ, 1'b0, 0, 0);
    runInstr(ANDI, 1'b0, 0, 0);
    runInstr(SLTI, 1'b0, 0, 0);
    runInstr(JMP, 1'b0, 0, 0);
    runInstr(JALOP, 1'b0, 0, 0);

    // sw abandoned by reset while memory is still stalling
    applyStimulus(SW, 1'b0, 1'b1, fetchWord(1'b1), 1'b0, "rst fetch");
    w = '0; w.alusrcb = 2'b11;
    applyStimulus(SW, 1'b0, 1'b0, w, 1'b0, "rst decode");
    w = '0; w.alusrca = 1'b1; w.alusrcb = 2'b10;
    applyStimulus(SW, 1'b0, 1'b0, w, 1'b0, "rst memadr");
    w = '0; w.mem_req = 1'b1; w.iord = 1'b1; w.memwrite = 1'b1;
    applyStimulus(SW, 1'b0, 1'b0, w, 1'b0, "rst memwr");
    memReady = 1'b0;
    #2;
    checkOutput("memwrite before reset", 32'(memwrite), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("memwrite in reset", 32'(memwrite), 32'd0);
    checkOutput("outputs in reset", 32'(actualBits), 32'h0);
    checkOutput("retired in reset", 32'(retired), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    retModel = '0;
    applyStimulus(SW, 1'b0, 1'b0, fetchWord(1'b0), 1'b0, "post-reset fetch");

    for (int i = 0; i < 15; i++) runInstr(ADDI, 1'b0, 0, 0);
    checkOutput("retired at 15", 32'(retired), 32'd15);
    runInstr(ADDI, 1'b0, 0, 0);
    checkOutput("retired wrapped", 32'(retired), 32'd0);

    @(negedge clk);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
